// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one SRAM-like bus between the fetch-stage instruction
// port and the mem-stage data port. Each access runs address phase, data phase,
// then a one-cycle response in which the owning port sees its done pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/addr            fetch request (held until inst_done)
//   inst_rdata/done/stall    fetch result, completion pulse, stall request
//   data_req/wr/wen/addr/wdata  data request (held until data_done)
//   data_rdata/done/stall    data result, completion pulse, stall request
//   bus_req/wr/wen/addr/wdata   bus address phase request and latched fields
//   bus_addr_ok/data_ok/rdata   bus handshakes and read data
//   bus_err                  pulse when an access is aborted by timeout
module cpu_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  localparam int unsigned CntW = 8;
  // Last count value before a wait phase is considered expired
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} arbStateT;

  arbStateT state, nextState;

  logic              ownerData;  // 1: data port owns the current access
  logic              latWr;
  logic [3:0]        latWen;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [CntW-1:0]   waitCnt;
  logic              errFlag;
  logic [DATA_W-1:0] instRdataQ;
  logic [DATA_W-1:0] dataRdataQ;

  logic grant;
  logic grantData;
  logic captureOk;
  logic abort;
  logic waitExpired;

  assign waitExpired = (waitCnt == CntLast);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= StIdle;
    else     state <= nextState;
  end

  // Next-state logic; data has fixed priority over fetch
  always_comb begin
    nextState = state;
    grant     = 1'b0;
    grantData = 1'b0;
    captureOk = 1'b0;
    abort     = 1'b0;
    unique case (state)
      StIdle: begin
        if (data_req || inst_req) begin
          grant     = 1'b1;
          grantData = data_req;
          nextState = StAddr;
        end
      end
      StAddr: begin
        // addr_ok wins over a timeout expiring in the same cycle
        if (bus_addr_ok) begin
          nextState = StData;
        end else if (waitExpired) begin
          abort     = 1'b1;
          nextState = StResp;
        end
      end
      StData: begin
        if (bus_data_ok) begin
          captureOk = 1'b1;
          nextState = StResp;
        end else if (waitExpired) begin
          abort     = 1'b1;
          nextState = StResp;
        end
      end
      StResp:  nextState = StIdle;  // never re-grant here, requester drops req
      default: nextState = StIdle;
    endcase
  end

  // Latched access fields, wait counter, error flag and read data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ownerData  <= 1'b0;
      latWr      <= 1'b0;
      latWen     <= '0;
      latAddr    <= '0;
      latWdata   <= '0;
      waitCnt    <= '0;
      errFlag    <= 1'b0;
      instRdataQ <= '0;
      dataRdataQ <= '0;
    end else begin
      if (grant) begin
        ownerData <= grantData;
        latWr     <= grantData & data_wr;
        latWen    <= grantData ? data_wen : 4'b0000;
        latAddr   <= grantData ? data_addr : inst_addr;
        latWdata  <= grantData ? data_wdata : '0;
        errFlag   <= 1'b0;
      end
      if (abort) errFlag <= 1'b1;

      // Cleared on entry to ADDR and to DATA, counts while waiting
      if (grant || (state == StAddr && bus_addr_ok)) begin
        waitCnt <= '0;
      end else if (state == StAddr || state == StData) begin
        waitCnt <= waitCnt + CntW'(1);
      end

      if (captureOk && !latWr) begin
        if (ownerData) dataRdataQ <= bus_rdata;
        else           instRdataQ <= bus_rdata;
      end
      if (abort) begin
        if (ownerData) dataRdataQ <= '0;
        else           instRdataQ <= '0;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus_req   = 1'b0;
    inst_done = 1'b0;
    data_done = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      StAddr: bus_req = 1'b1;
      StResp: begin
        inst_done = !ownerData;
        data_done = ownerData;
        bus_err   = errFlag;
      end
      default: ;
    endcase
  end

  assign bus_wr     = latWr;
  assign bus_wen    = latWen;
  assign bus_addr   = latAddr;
  assign bus_wdata  = latWdata;
  assign inst_rdata = instRdataQ;
  assign data_rdata = dataRdataQ;

  // Stall requests are the only combinational paths from inputs
  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed vector table, hand-written
// collision / held-request / mid-access reset sequences, and randomized
// accesses checked against a transaction-level timing model.
module tb_cpu_bus_arbiter;

  localparam int TO = 4;

  typedef struct {
    bit          isData;
    bit          wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // what the bus returns for this access
    int          dA;      // cycles of bus_req before addr_ok
    int          dD;      // cycles in data phase before data_ok
  } accT;

  typedef struct {
    accT         a;
    int          expK;
    logic [31:0] expRd;
    bit          expErr;
    int          expBreq;
  } vecT;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_done, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_done, data_stall;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, bus_err;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic accT mkAcc(input bit isData, input bit wr, input logic [3:0] wen,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int dA, input int dD);
    accT a;
    a.isData = isData; a.wr = wr; a.wen = wen; a.addr = addr;
    a.wdata = wdata; a.rdata = rdata; a.dA = dA; a.dD = dD;
    return a;
  endfunction

  function automatic vecT mkVec(input accT a, input int k, input logic [31:0] rd,
                                input bit err, input int breq);
    vecT v;
    v.a = a; v.expK = k; v.expRd = rd; v.expErr = err; v.expBreq = breq;
    return v;
  endfunction

  // Transaction-level timing model: samples from request to done pulse
  function automatic int latOf(input accT a);
    if (a.dA >= TO) return 1 + TO;
    if (a.dD >= TO) return 2 + a.dA + TO;
    return 3 + a.dA + a.dD;
  endfunction

  function automatic bit errOf(input accT a);
    return (a.dA >= TO) || (a.dD >= TO);
  endfunction

  function automatic int breqOf(input accT a);
    return (a.dA >= TO) ? TO : a.dA + 1;
  endfunction

  // Bus responder: serves accesses from rspQ in the order bus_req rises
  accT rspQ[$];
  accT rspCur;
  bit  rspManual = 1'b0;
  bit  rspAct = 1'b0;
  bit  rspInData = 1'b0;
  int  aCnt = 0;
  int  dCnt = 0;

  always @(negedge clk) begin
    if (rspManual || rst) begin
      rspAct    = 1'b0;
      rspInData = 1'b0;
      if (rst && !rspManual) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
      end
    end else begin
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (bus_req) begin
        if (!rspAct) begin
          rspAct = 1'b1;
          aCnt   = 0;
          if (rspQ.size() > 0) rspCur = rspQ.pop_front();
        end
        if (aCnt == rspCur.dA) begin
          bus_addr_ok = 1'b1;
          rspInData   = 1'b1;
          dCnt        = 0;
          rspAct      = 1'b0;
        end else begin
          aCnt++;
        end
      end else begin
        rspAct = 1'b0;
        if (rspInData) begin
          if (dCnt == rspCur.dD) begin
            bus_data_ok = 1'b1;
            bus_rdata   = rspCur.rdata;
            rspInData   = 1'b0;
          end else begin
            dCnt++;
          end
        end
      end
    end
  end

  // Results of the last runAcc, index 0 = inst port, 1 = data port
  int          resK[2];
  logic [31:0] resRd[2];
  bit          resErr[2];
  int          resPulses, resErrPulses, resBreq;
  bit          resLatchBad, resStallBad;

  // Run one access per requested port; requesters drop req on their done
  task automatic runAcc(input bit useI, input bit useD, input accT ai, input accT ad);
    accT order[$];
    accT cur;
    bit  pending[2];
    bit  granted[2];
    int  rises;
    bit  prevBreq;
    int  doneAll;
    order = {};
    if (useD) order.push_back(ad);
    if (useI) order.push_back(ai);
    foreach (order[i]) rspQ.push_back(order[i]);
    resK = '{-1, -1}; resRd = '{32'h0, 32'h0}; resErr = '{1'b0, 1'b0};
    resPulses = 0; resErrPulses = 0; resBreq = 0; resLatchBad = 1'b0; resStallBad = 1'b0;
    inst_req = useI; inst_addr = ai.addr;
    data_req = useD; data_wr = ad.wr; data_wen = ad.wen;
    data_addr = ad.addr; data_wdata = ad.wdata;
    pending[0] = useI; pending[1] = useD;
    granted[0] = 1'b0; granted[1] = 1'b0;
    rises = 0; prevBreq = 1'b0; doneAll = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus_req && !prevBreq) begin
        if (rises < order.size()) begin
          cur = order[rises];
          granted[cur.isData] = 1'b1;
        end else begin
          resLatchBad = 1'b1;
        end
        rises++;
      end
      prevBreq = bus_req;
      if (bus_req) resBreq++;
      if (rises > 0 && rises <= order.size()) begin
        if (bus_addr !== cur.addr || bus_wr !== (cur.isData & cur.wr) ||
            bus_wen !== (cur.isData ? cur.wen : 4'b0000) ||
            (cur.isData && bus_wdata !== cur.wdata))
          resLatchBad = 1'b1;
      end
      if (inst_done) begin
        resPulses++;
        if (resK[0] < 0) begin resK[0] = k; resRd[0] = inst_rdata; resErr[0] = bus_err; end
      end
      if (data_done) begin
        resPulses++;
        if (resK[1] < 0) begin resK[1] = k; resRd[1] = data_rdata; resErr[1] = bus_err; end
      end
      if (bus_err) resErrPulses++;
      if (inst_stall !== (pending[0] && !inst_done)) resStallBad = 1'b1;
      if (data_stall !== (pending[1] && !data_done)) resStallBad = 1'b1;
      if (inst_done && pending[0]) begin pending[0] = 1'b0; inst_req = 1'b0; end
      if (data_done && pending[1]) begin pending[1] = 1'b0; data_req = 1'b0; end
      // Inputs wander after grant; the access in flight must not notice
      if (granted[1] && pending[1]) begin
        data_addr = $urandom; data_wdata = $urandom;
        data_wen = 4'($urandom_range(0, 15)); data_wr = 1'($urandom_range(0, 1));
      end
      if (granted[0] && pending[0]) inst_addr = $urandom;
      if (!pending[0] && !pending[1] && doneAll < 0) doneAll = k;
      if (doneAll >= 0 && k >= doneAll + 2) break;
    end
    inst_req = 1'b0; data_req = 1'b0;
    rspQ.delete();
  endtask

  vecT         tbl[7];
  logic [31:0] modelDataRd;
  logic [31:0] modelInstRd;
  int          hk[3];
  logic [31:0] hr[3];

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    tbl[0] = mkVec(mkAcc(0, 0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C01_0001, 0, 0),
                   3, 32'h3C01_0001, 0, 1);
    tbl[1] = mkVec(mkAcc(1, 0, 4'hF, 32'h0000_0010, 32'h0, 32'h1122_3344, 0, 0),
                   3, 32'h1122_3344, 0, 1);
    tbl[2] = mkVec(mkAcc(1, 1, 4'b0011, 32'h0000_0020, 32'h0000_BEEF, 32'hDEAD_DEAD, 3, 0),
                   6, 32'h1122_3344, 0, 4);
    tbl[3] = mkVec(mkAcc(1, 0, 4'hF, 32'h0000_0030, 32'h0, 32'h5555_5555, 1000, 0),
                   5, 32'h0, 1, 4);
    tbl[4] = mkVec(mkAcc(0, 0, 4'h0, 32'h0000_0040, 32'h0, 32'h6666_6666, 0, 1000),
                   6, 32'h0, 1, 1);
    tbl[5] = mkVec(mkAcc(1, 0, 4'hF, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1, 2),
                   6, 32'hCAFE_F00D, 0, 2);
    tbl[6] = mkVec(mkAcc(1, 1, 4'b1100, 32'h0000_0048, 32'h1234_0000, 32'h7777_7777, 0, 3),
                   6, 32'hCAFE_F00D, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst bus_req", 64'(bus_req), 64'(0));
    chk("rst bus_fields", {bus_wdata, bus_addr}, 64'(0));
    chk("rst wen_wr_err", 64'({bus_wen, bus_wr, bus_err}), 64'(0));
    chk("rst done", 64'({inst_done, data_done, inst_stall, data_stall}), 64'(0));
    chk("rst rdata", {inst_rdata, data_rdata}, 64'(0));
    rst = 1'b0;

    modelDataRd = '0;
    modelInstRd = '0;
    for (int r = 0; r < 7; r++) begin
      int p;
      p = tbl[r].a.isData ? 1 : 0;
      runAcc(!tbl[r].a.isData, tbl[r].a.isData, tbl[r].a, tbl[r].a);
      chk($sformatf("vec%0d done_cycle", r), 64'(resK[p]), 64'(tbl[r].expK));
      chk($sformatf("vec%0d rdata", r), 64'(resRd[p]), 64'(tbl[r].expRd));
      chk($sformatf("vec%0d bus_err", r), 64'(resErr[p]), 64'(tbl[r].expErr));
      chk($sformatf("vec%0d bus_req_cycles", r), 64'(resBreq), 64'(tbl[r].expBreq));
      chk($sformatf("vec%0d done_pulses", r), 64'(resPulses), 64'(1));
      chk($sformatf("vec%0d latch_bad", r), 64'(resLatchBad), 64'(0));
      chk($sformatf("vec%0d stall_bad", r), 64'(resStallBad), 64'(0));
      if (p == 1) modelDataRd = tbl[r].expRd;
      else        modelInstRd = tbl[r].expRd;
    end

    // Randomized single and colliding accesses against the timing model
    for (int it = 0; it < 40; it++) begin
      int  sel, kI, kD, nErr;
      bit  useI, useD;
      accT ai, ad;
      sel  = int'($urandom_range(1, 3));
      useI = sel[0];
      useD = sel[1];
      ai = mkAcc(0, 0, 4'h0, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      ad = mkAcc(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      runAcc(useI, useD, ai, ad);
      kD = latOf(ad);
      kI = useD ? latOf(ad) + 1 + latOf(ai) : latOf(ai);
      nErr = 0;
      if (useD) begin
        modelDataRd = errOf(ad) ? 32'h0 : (ad.wr ? modelDataRd : ad.rdata);
        chk($sformatf("rnd%0d data done_cycle", it), 64'(resK[1]), 64'(kD));
        chk($sformatf("rnd%0d data rdata", it), 64'(resRd[1]), 64'(modelDataRd));
        chk($sformatf("rnd%0d data err", it), 64'(resErr[1]), 64'(errOf(ad)));
        nErr += int'(errOf(ad));
      end
      if (useI) begin
        modelInstRd = errOf(ai) ? 32'h0 : ai.rdata;
        chk($sformatf("rnd%0d inst done_cycle", it), 64'(resK[0]), 64'(kI));
        chk($sformatf("rnd%0d inst rdata", it), 64'(resRd[0]), 64'(modelInstRd));
        chk($sformatf("rnd%0d inst err", it), 64'(resErr[0]), 64'(errOf(ai)));
        nErr += int'(errOf(ai));
      end
      chk($sformatf("rnd%0d pulses", it), 64'(resPulses), 64'(int'(useI) + int'(useD)));
      chk($sformatf("rnd%0d err_pulses", it), 64'(resErrPulses), 64'(nErr));
      chk($sformatf("rnd%0d bus_req_cycles", it), 64'(resBreq),
          64'((useI ? breqOf(ai) : 0) + (useD ? breqOf(ad) : 0)));
      chk($sformatf("rnd%0d latch_bad", it), 64'(resLatchBad), 64'(0));
      chk($sformatf("rnd%0d stall_bad", it), 64'(resStallBad), 64'(0));
    end

    // Collision: data served first, inst done four cycles after data done
    runAcc(1'b1, 1'b1,
           mkAcc(0, 0, 4'h0, 32'hBFC0_0004, 32'h0, 32'hAABB_CCDD, 0, 0),
           mkAcc(1, 0, 4'hF, 32'h0000_0010, 32'h0, 32'h1122_3344, 0, 0));
    chk("coll data done_cycle", 64'(resK[1]), 64'(3));
    chk("coll data rdata", 64'(resRd[1]), 64'(32'h1122_3344));
    chk("coll inst done_cycle", 64'(resK[0]), 64'(7));
    chk("coll inst rdata", 64'(resRd[0]), 64'(32'hAABB_CCDD));
    chk("coll latch_bad", 64'(resLatchBad), 64'(0));
    chk("coll stall_bad", 64'(resStallBad), 64'(0));

    // Held inst_req: one grant and one done per four cycles
    begin
      int  nDone, rises;
      bit  prevB;
      rspQ.push_back(mkAcc(0, 0, 4'h0, 32'h100, 32'h0, 32'h0101_0101, 0, 0));
      rspQ.push_back(mkAcc(0, 0, 4'h0, 32'h100, 32'h0, 32'h0202_0202, 0, 0));
      rspQ.push_back(mkAcc(0, 0, 4'h0, 32'h100, 32'h0, 32'h0303_0303, 0, 0));
      hk = '{-1, -1, -1};
      hr = '{32'h0, 32'h0, 32'h0};
      nDone = 0; rises = 0; prevB = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h0000_0100;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (bus_req && !prevB) rises++;
        prevB = bus_req;
        if (inst_done) begin
          if (nDone < 3) begin hk[nDone] = k; hr[nDone] = inst_rdata; end
          nDone++;
          if (nDone == 3) inst_req = 1'b0;
        end
      end
      inst_req = 1'b0;
      rspQ.delete();
      chk("held done_pulses", 64'(nDone), 64'(3));
      chk("held grants", 64'(rises), 64'(3));
      chk("held done0_cycle", 64'(hk[0]), 64'(3));
      chk("held done1_cycle", 64'(hk[1]), 64'(7));
      chk("held done2_cycle", 64'(hk[2]), 64'(11));
      chk("held rdata2", 64'(hr[2]), 64'(32'h0303_0303));
      modelInstRd = hr[2];
    end

    // Reset while in DATA, then a late data_ok that must be ignored
    begin
      bit lateDone;
      rspManual = 1'b1;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      data_req = 1'b1; data_wr = 1'b0; data_wen = 4'hF; data_addr = 32'h0000_0050;
      @(negedge clk);
      chk("rstmid bus_req", 64'(bus_req), 64'(1));
      bus_addr_ok = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b0;
      chk("rstmid in_data", 64'({bus_req, bus_addr}), 64'({1'b0, 32'h0000_0050}));
      rst = 1'b1; data_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid bus_fields", {bus_wdata, bus_addr}, 64'(0));
      chk("rstmid ctrl", 64'({bus_req, bus_wr, bus_wen, bus_err, inst_done, data_done}), 64'(0));
      chk("rstmid rdata", {inst_rdata, data_rdata}, 64'(0));
      bus_rdata = 32'h9999_9999; bus_data_ok = 1'b1;
      lateDone = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        bus_data_ok = 1'b0;
        if (inst_done || data_done || bus_err || bus_req) lateDone = 1'b1;
      end
      chk("rstmid late_data_ok", 64'({lateDone, data_rdata}), 64'(0));
      rspManual = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
